// File: rtl/uart_cmd_ctrl_if.sv
// uart_cmd_ctrl_if: bundles the receiver strobe, game tick and the command
// outputs of uart_cmd_ctrl. DEPTH must match the controller's DEPTH so that
// o_count has the same width on both sides.
interface uart_cmd_ctrl_if #(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          i_rx_wr;
    logic [7:0]    i_rx_data;
    logic          i_tick;
    logic [1:0]    o_dir;
    logic          o_dir_valid;
    logic          o_pause;
    logic          o_restart;
    logic          o_overflow;
    logic [CW-1:0] o_count;

    // Receiver / game side: drives strobe, byte and tick, observes commands.
    modport master (
        output i_rx_wr, i_rx_data, i_tick,
        input  o_dir, o_dir_valid, o_pause, o_restart, o_overflow, o_count
    );

    // Controller side.
    modport slave (
        input  i_rx_wr, i_rx_data, i_tick,
        output o_dir, o_dir_valid, o_pause, o_restart, o_overflow, o_count
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: command controller between the UART receiver and the snake
// game logic. Captures each receiver byte once on the rising edge of its
// (possibly multi-cycle) strobe, decodes WASD turns into a small FIFO, releases
// one turn per game tick, and handles pause-toggle ('p') and restart ('r').
//
// Build option: define UART_CMD_UPPERCASE_EN to make 'W','A','S','D','P','R'
// decode like their lowercase forms; otherwise uppercase bytes are ignored.
//
// Capture FSM states:
//   state     | meaning
//   ST_ARM    | first cycle after reset; prev_wr loads, no capture allowed
//   ST_IDLE   | waiting for a rising edge of i_rx_wr
//   ST_DECODE | byte register holds a fresh byte; its command acts this cycle
module uart_cmd_ctrl #(
    parameter int         DEPTH    = 2,
    parameter logic [1:0] INIT_DIR = 2'b01
) (
    input logic         i_clk,
    input logic         rst,
    uart_cmd_ctrl_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_ARM    = 2'd0,
        ST_IDLE   = 2'd1,
        ST_DECODE = 2'd2
    } cap_state_t;

    cap_state_t    state_q;
    cap_state_t    state_d;
    logic          prev_wr_q;
    logic [7:0]    byte_q;
    logic          rx_edge;
    logic          capture;
    logic          decode_en;

    logic          cmd_turn;
    logic          cmd_pause;
    logic          cmd_restart;
    logic [1:0]    cmd_dir;

    logic [1:0]    mem_q [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;

    logic [1:0]    dir_q;
    logic          dir_valid_q;
    logic          pause_q;
    logic          restart_q;
    logic          overflow_q;

    logic [1:0]    ref_dir;
    logic          turn_legal;
    logic          queue_full;
    logic          do_pop;
    logic          do_push;
    logic          do_drop;

    assign rx_edge = bus.i_rx_wr & ~prev_wr_q;

    // Capture FSM state register.
    always_ff @(posedge i_clk) begin
        if (rst) begin
            state_q <= ST_ARM;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture FSM next-state logic: a byte is decoded exactly one cycle after capture.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARM:    state_d = ST_IDLE;
            ST_IDLE:   if (rx_edge) state_d = ST_DECODE;
            ST_DECODE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Capture FSM outputs: when to latch the byte and when to act on it.
    always_comb begin
        capture   = 1'b0;
        decode_en = 1'b0;
        case (state_q)
            ST_IDLE:   capture   = rx_edge;
            ST_DECODE: decode_en = 1'b1;
            default: begin
                capture   = 1'b0;
                decode_en = 1'b0;
            end
        endcase
    end

    // Strobe history and byte register; a strobe held through reset release
    // is absorbed by ST_ARM and never captured.
    always_ff @(posedge i_clk) begin
        if (rst) begin
            prev_wr_q <= 1'b0;
            byte_q    <= 8'h00;
        end else begin
            prev_wr_q <= bus.i_rx_wr;
            if (capture) begin
                byte_q <= bus.i_rx_data;
            end
        end
    end

    // Command decode from the byte register, valid only in the decode cycle.
    always_comb begin
        cmd_turn    = 1'b0;
        cmd_pause   = 1'b0;
        cmd_restart = 1'b0;
        cmd_dir     = 2'b00;
        if (decode_en) begin
            case (byte_q)
                8'h77: begin cmd_turn = 1'b1; cmd_dir = 2'b00; end
                8'h64: begin cmd_turn = 1'b1; cmd_dir = 2'b01; end
                8'h73: begin cmd_turn = 1'b1; cmd_dir = 2'b10; end
                8'h61: begin cmd_turn = 1'b1; cmd_dir = 2'b11; end
                8'h70: cmd_pause   = 1'b1;
                8'h72: cmd_restart = 1'b1;
`ifdef UART_CMD_UPPERCASE_EN
                8'h57: begin cmd_turn = 1'b1; cmd_dir = 2'b00; end
                8'h44: begin cmd_turn = 1'b1; cmd_dir = 2'b01; end
                8'h53: begin cmd_turn = 1'b1; cmd_dir = 2'b10; end
                8'h41: begin cmd_turn = 1'b1; cmd_dir = 2'b11; end
                8'h50: cmd_pause   = 1'b1;
                8'h52: cmd_restart = 1'b1;
`endif
                default: begin
                    cmd_turn    = 1'b0;
                    cmd_pause   = 1'b0;
                    cmd_restart = 1'b0;
                end
            endcase
        end
    end

    // Turn legality is judged against the newest pending turn (or the current
    // direction when nothing is pending), evaluated before any same-cycle pop.
    always_comb begin
        ref_dir    = (count_q != '0) ? mem_q[tail_q - PTR_ONE] : dir_q;
        turn_legal = cmd_turn && (cmd_dir != ref_dir) && (cmd_dir != (ref_dir ^ 2'b10));
        queue_full = (count_q == CNT_FULL);
        do_pop     = bus.i_tick && !pause_q && (count_q != '0) && !cmd_restart;
        do_push    = turn_legal && (!queue_full || do_pop);
        do_drop    = turn_legal && queue_full && !do_pop;
    end

    // Queue storage; contents are don't-care while unoccupied.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[tail_q] <= cmd_dir;
        end
    end

    // Queue pointers and occupancy; restart flushes.
    always_ff @(posedge i_clk) begin
        if (rst || cmd_restart) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                tail_q <= tail_q + PTR_ONE;
            end
            if (do_pop) begin
                head_q <= head_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Direction, pause, overflow and the one-cycle pulses.
    always_ff @(posedge i_clk) begin
        if (rst) begin
            dir_q       <= INIT_DIR;
            dir_valid_q <= 1'b0;
            pause_q     <= 1'b0;
            restart_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            dir_valid_q <= do_pop;
            restart_q   <= cmd_restart;
            if (cmd_restart) begin
                dir_q      <= INIT_DIR;
                pause_q    <= 1'b0;
                overflow_q <= 1'b0;
            end else begin
                if (do_pop) begin
                    dir_q <= mem_q[head_q];
                end
                if (cmd_pause) begin
                    pause_q <= ~pause_q;
                end
                if (do_drop) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    assign bus.o_dir       = dir_q;
    assign bus.o_dir_valid = dir_valid_q;
    assign bus.o_pause     = pause_q;
    assign bus.o_restart   = restart_q;
    assign bus.o_overflow  = overflow_q;
    assign bus.o_count     = count_q;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed scenarios plus randomized byte/tick traffic
// checked against a queue-based reference model of uart_cmd_ctrl.
module tb_uart_cmd_ctrl;
    localparam int DEPTH = 2;
    localparam logic [1:0] INIT_DIR = 2'b01;

    logic i_clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [1:0] m_dir;
    bit         m_pause;
    bit         m_ovf;
    logic [1:0] m_q[$];

    uart_cmd_ctrl_if #(.DEPTH(DEPTH)) bus ();

    uart_cmd_ctrl #(.DEPTH(DEPTH), .INIT_DIR(INIT_DIR)) dut (
        .i_clk (i_clk),
        .rst   (rst),
        .bus   (bus.slave)
    );

    always #20 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_rx_wr = 1'b0;
        bus.i_rx_data = 8'h00;
        bus.i_tick = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        m_dir = INIT_DIR;
        m_pause = 1'b0;
        m_ovf = 1'b0;
        m_q.delete();
    endtask

    // Strobe held for 'hold' edges; optional tick in the decode cycle.
    // Counts restart and dir_valid pulses seen along the way.
    task automatic send(input logic [7:0] b, input int hold, input bit tick_dec,
                        output int rs, output int vs);
        rs = 0;
        vs = 0;
        bus.i_rx_data = b;
        bus.i_rx_wr = 1'b1;
        for (int c = 1; c <= hold + 3; c++) begin
            step();
            if (bus.o_restart === 1'b1) rs++;
            if (bus.o_dir_valid === 1'b1) vs++;
            bus.i_tick = (c == 1) ? tick_dec : 1'b0;
            if (c == hold) bus.i_rx_wr = 1'b0;
        end
    endtask

    task automatic tick_once(output logic v1, output logic v2);
        bus.i_tick = 1'b1;
        step();
        bus.i_tick = 1'b0;
        v1 = bus.o_dir_valid;
        step();
        v2 = bus.o_dir_valid;
    endtask

    // -1 ignored, 0..3 direction, 4 pause, 5 restart
    function automatic int cmd_of(input logic [7:0] b);
        case (b)
            8'h77: return 0;
            8'h64: return 1;
            8'h73: return 2;
            8'h61: return 3;
            8'h70: return 4;
            8'h72: return 5;
`ifdef UART_CMD_UPPERCASE_EN
            8'h57: return 0;
            8'h44: return 1;
            8'h53: return 2;
            8'h41: return 3;
            8'h50: return 4;
            8'h52: return 5;
`endif
            default: return -1;
        endcase
    endfunction

    task automatic model_byte(input logic [7:0] b, input bit tick_dec,
                              output int exp_v, output int exp_r);
        int c;
        logic [1:0] r;
        logic [1:0] nd;
        bit pop;
        c = cmd_of(b);
        exp_v = 0;
        exp_r = 0;
        if (c == 5) begin
            m_dir = INIT_DIR;
            m_q.delete();
            m_pause = 1'b0;
            m_ovf = 1'b0;
            exp_r = 1;
            return;
        end
        pop = tick_dec && !m_pause && (m_q.size() > 0);
        r = (m_q.size() > 0) ? m_q[$] : m_dir;
        if (pop) begin
            m_dir = m_q.pop_front();
            exp_v = 1;
        end
        if (c >= 0 && c < 4) begin
            nd = 2'(c);
            if (nd != r && nd != (r ^ 2'b10)) begin
                if (m_q.size() < DEPTH) m_q.push_back(nd);
                else m_ovf = 1'b1;
            end
        end
        if (c == 4) m_pause = !m_pause;
    endtask

    task automatic test_reset();
        int rs, vs;
        do_reset();
        checks++; if (bus.o_dir !== INIT_DIR) begin errors++; $display("FAIL reset_dir got %0d expected %0d", bus.o_dir, INIT_DIR); end
        checks++; if (bus.o_count !== 0) begin errors++; $display("FAIL reset_count got %0d expected 0", bus.o_count); end
        checks++; if ({bus.o_dir_valid, bus.o_pause, bus.o_restart, bus.o_overflow} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got %b expected 0000", {bus.o_dir_valid, bus.o_pause, bus.o_restart, bus.o_overflow}); end
        send(8'h70, 1, 1'b0, rs, vs);
        send(8'h77, 1, 1'b0, rs, vs);
        bus.i_rx_data = 8'h77;
        bus.i_rx_wr = 1'b1;
        step();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (3) step();
        bus.i_rx_wr = 1'b0;
        repeat (3) step();
        checks++; if (bus.o_count !== 0) begin errors++; $display("FAIL midreset_count got %0d expected 0", bus.o_count); end
        checks++; if (bus.o_pause !== 1'b0) begin errors++; $display("FAIL midreset_pause got %0d expected 0", bus.o_pause); end
        checks++; if (bus.o_dir !== INIT_DIR) begin errors++; $display("FAIL midreset_dir got %0d expected %0d", bus.o_dir, INIT_DIR); end
    endtask

    task automatic test_capture();
        int rs, vs;
        logic v1, v2;
        do_reset();
        send(8'h77, 3, 1'b0, rs, vs);
        checks++; if (bus.o_count !== 1) begin errors++; $display("FAIL capture_count got %0d expected 1", bus.o_count); end
        tick_once(v1, v2);
        checks++; if (bus.o_dir !== 2'b00) begin errors++; $display("FAIL capture_dir got %0d expected 0", bus.o_dir); end
        checks++; if ({v1, v2} !== 2'b10) begin errors++; $display("FAIL capture_valid_pulse got %b expected 10", {v1, v2}); end
    endtask

    task automatic test_legality();
        int rs, vs;
        do_reset();
        send(8'h61, 1, 1'b0, rs, vs);
        send(8'h64, 2, 1'b0, rs, vs);
        checks++; if (bus.o_count !== 0) begin errors++; $display("FAIL legality_count got %0d expected 0", bus.o_count); end
        checks++; if (bus.o_overflow !== 1'b0) begin errors++; $display("FAIL legality_ovf got %0d expected 0", bus.o_overflow); end
    endtask

    task automatic test_overflow();
        int rs, vs;
        logic v1, v2;
        do_reset();
        send(8'h77, 1, 1'b0, rs, vs);
        send(8'h61, 1, 1'b0, rs, vs);
        send(8'h73, 1, 1'b0, rs, vs);
        checks++; if (bus.o_count !== 2) begin errors++; $display("FAIL ovf_count got %0d expected 2", bus.o_count); end
        checks++; if (bus.o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0d expected 1", bus.o_overflow); end
        tick_once(v1, v2);
        checks++; if (bus.o_dir !== 2'b00) begin errors++; $display("FAIL ovf_tick1 got %0d expected 0", bus.o_dir); end
        tick_once(v1, v2);
        checks++; if (bus.o_dir !== 2'b11) begin errors++; $display("FAIL ovf_tick2 got %0d expected 3", bus.o_dir); end
    endtask

    task automatic test_pause();
        int rs, vs;
        logic v1, v2;
        do_reset();
        send(8'h70, 1, 1'b0, rs, vs);
        checks++; if (bus.o_pause !== 1'b1) begin errors++; $display("FAIL pause_set got %0d expected 1", bus.o_pause); end
        send(8'h77, 1, 1'b0, rs, vs);
        tick_once(v1, v2);
        checks++; if ({bus.o_dir, bus.o_count, v1} !== {2'b01, 2'd1, 1'b0}) begin
            errors++; $display("FAIL pause_tick got dir %0d count %0d valid %0d expected 1 1 0", bus.o_dir, bus.o_count, v1); end
        send(8'h70, 1, 1'b0, rs, vs);
        tick_once(v1, v2);
        checks++; if ({bus.o_dir, v1} !== {2'b00, 1'b1}) begin
            errors++; $display("FAIL unpause_tick got dir %0d valid %0d expected 0 1", bus.o_dir, v1); end
    endtask

    task automatic test_restart();
        int rs, vs;
        do_reset();
        send(8'h77, 1, 1'b0, rs, vs);
        send(8'h61, 1, 1'b0, rs, vs);
        send(8'h73, 1, 1'b0, rs, vs);
        send(8'h70, 1, 1'b0, rs, vs);
        send(8'h72, 1, 1'b0, rs, vs);
        checks++; if (rs !== 1) begin errors++; $display("FAIL restart_pulses got %0d expected 1", rs); end
        checks++; if ({bus.o_dir, bus.o_count, bus.o_overflow, bus.o_pause} !== {2'b01, 2'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL restart_state got dir %0d count %0d ovf %0d pause %0d expected 1 0 0 0",
                               bus.o_dir, bus.o_count, bus.o_overflow, bus.o_pause); end
        send(8'h77, 1, 1'b0, rs, vs);
        send(8'h61, 1, 1'b0, rs, vs);
        send(8'h72, 1, 1'b1, rs, vs);
        checks++; if ({bus.o_dir, bus.o_count, vs[1:0]} !== {2'b01, 2'd0, 2'd0}) begin
            errors++; $display("FAIL restart_tick_ignored got dir %0d count %0d valids %0d expected 1 0 0", bus.o_dir, bus.o_count, vs); end
    endtask

    task automatic test_back_to_back();
        int rs, vs;
        logic v1, v2;
        do_reset();
        send(8'h77, 1, 1'b0, rs, vs);
        send(8'h61, 1, 1'b0, rs, vs);
        send(8'h73, 2, 1'b1, rs, vs);
        checks++; if ({bus.o_count, bus.o_dir, bus.o_overflow, vs[1:0]} !== {2'd2, 2'b00, 1'b0, 2'd1}) begin
            errors++; $display("FAIL pushpop got count %0d dir %0d ovf %0d valids %0d expected 2 0 0 1",
                               bus.o_count, bus.o_dir, bus.o_overflow, vs); end
        tick_once(v1, v2);
        checks++; if (bus.o_dir !== 2'b11) begin errors++; $display("FAIL pushpop_tick1 got %0d expected 3", bus.o_dir); end
        tick_once(v1, v2);
        checks++; if (bus.o_dir !== 2'b10) begin errors++; $display("FAIL pushpop_tick2 got %0d expected 2", bus.o_dir); end
        do_reset();
        send(8'h57, 1, 1'b0, rs, vs);
`ifdef UART_CMD_UPPERCASE_EN
        checks++; if (bus.o_count !== 1) begin errors++; $display("FAIL upper_W got %0d expected 1", bus.o_count); end
`else
        checks++; if (bus.o_count !== 0) begin errors++; $display("FAIL upper_W got %0d expected 0", bus.o_count); end
`endif
    endtask

    task automatic test_random();
        logic [7:0] pool [12] = '{8'h77, 8'h64, 8'h73, 8'h61, 8'h70, 8'h72,
                                  8'h57, 8'h44, 8'h53, 8'h41, 8'h50, 8'h52};
        int rs, vs, ev, er, sel;
        logic [7:0] b;
        logic v1, v2;
        bit td;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 15);
            if (sel < 5) begin
                tick_once(v1, v2);
                ev = (!m_pause && m_q.size() > 0) ? 1 : 0;
                if (ev == 1) m_dir = m_q.pop_front();
                checks++; if ({v1, v2} !== {ev[0], 1'b0}) begin
                    errors++; $display("FAIL rand_tick_valid op %0d got %b expected %0d0", n, {v1, v2}, ev); end
            end else begin
                if (sel == 15) b = 8'($urandom_range(0, 255));
                else if (sel == 14 && $urandom_range(0, 3) != 0) b = 8'h77;
                else b = pool[$urandom_range(0, 11)];
                td = 1'($urandom_range(0, 1));
                send(b, $urandom_range(1, 3), td, rs, vs);
                model_byte(b, td, ev, er);
                checks++; if (rs !== er || vs !== ev) begin
                    errors++; $display("FAIL rand_pulses op %0d byte %h got restart %0d valid %0d expected %0d %0d", n, b, rs, vs, er, ev); end
            end
            checks++; if (bus.o_dir !== m_dir || int'(bus.o_count) !== m_q.size() ||
                          bus.o_pause !== m_pause || bus.o_overflow !== m_ovf) begin
                errors++; $display("FAIL rand_state op %0d got dir %0d count %0d pause %0d ovf %0d expected %0d %0d %0d %0d",
                                   n, bus.o_dir, bus.o_count, bus.o_pause, bus.o_overflow, m_dir, m_q.size(), m_pause, m_ovf); end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.i_rx_wr = 1'b0;
        bus.i_rx_data = 8'h00;
        bus.i_tick = 1'b0;
        test_reset();
        test_capture();
        test_legality();
        test_overflow();
        test_pause();
        test_restart();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
